ro_meas_sched: RTL and testbench
================================

Name: ro_meas_sched

Overview:
- Memory-mapped measurement scheduler for the short- and long-stage ring-oscillator sensors on the openMSP430 peripheral bus.
- Time-multiplexes the two RO enables, opening one fixed-length mclk window at a time.
- Snapshots each free-running RO counter before and after its window and computes the wrap-safe delta.
- Checks each delta against per-sensor low/high thresholds; flags glitch/undervoltage alarms and raises an IRQ.

Parameters:
BASE_ADDR, 15'h01C0, register base address (aligned to DEC_WD)
DEC_WD, 5, address decoder bit width (16 word slots)
SETTLE_CYC, 4, mclk cycles with enable low before the end snapshot (RO counter settle); minimum 1
WIN_W, 16, window counter width

Ports:
mclk  in  1  main system clock
puc_rst_n  in  1  asynchronous active-low reset
per_addr  in  14  peripheral word address
per_din  in  16  peripheral write data
per_en  in  1  peripheral enable
per_we  in  2  byte write enables; any bit set = write
per_dout  out  16  read data; 0 when not selected
ro_short_cnt  in  16  short-stage RO counter (RO domain, stable while ro_short_en low)
ro_long_cnt  in  16  long-stage RO counter (stable while ro_long_en low)
ro_short_en  out  1  short-stage RO enable
ro_long_en  out  1  long-stage RO enable
irq  out  1  alarm interrupt, level

Behaviour:
- Reset (puc_rst_n low, async): all registers 0; FSM IDLE; ro_short_en=ro_long_en=irq=0; per_dout=0.
- Register map (offsets):
  - 0x00 CTRL: b0 start (self-clearing, reads 0); b1 continuous; b2 short_sel; b3 long_sel; b4 irq_en; b5 abort (self-clearing).
  - 0x02 WINDOW: window length in cycles; 0 is treated as 1.
  - 0x04 S_LO; 0x06 S_HI; 0x08 L_LO; 0x0A L_HI: thresholds.
  - 0x0C S_RES; 0x0E L_RES: last deltas, read-only.
  - 0x10 STATUS: b0 busy (RO); b1 done; b2 s_low; b3 s_high; b4 l_low; b5 l_high. Bits 1-5 are sticky, write-1-to-clear.
  - 0x12 ERRCNT: saturating violation count; any write clears it.
- Reads: combinational, same cycle as per_en.
- FSM states: IDLE, PRE, RUN, SETTLE, EVAL; a sel flop chooses the sensor (short first).
- Start:
  - A CTRL write with start=1 while IDLE and (short_sel|long_sel) moves to PRE on the next edge.
  - Start is ignored while busy, or when neither sensor is selected (done stays unchanged).
- PRE (1 cycle): latch start snapshot of the selected counter.
- RUN: the selected enable is a registered output, high for exactly max(WINDOW,1) cycles; the other enable stays low.
- SETTLE: SETTLE_CYC cycles with both enables low.
- EVAL (1 cycle):
  - delta = end - start, modulo 2^16 (counter wrap handled).
  - Write delta to *_RES.
  - Set low flag if delta < LO; set high flag if delta > HI (unsigned compare).
  - If either flag is hit, increment ERRCNT, saturating at 0xFFFF.
- After EVAL:
  - If sel=short and long_sel is set, run the long sensor from PRE.
  - Otherwise the sequence is complete: set done. Return to PRE with the first selected sensor if continuous, else go to IDLE.
- busy = state != IDLE.
- Abort write: FSM to IDLE next edge, enables low, no RES/flag update, done not set. Abort beats start in the same write.
- CTRL writes during busy update continuous/irq_en/sel bits. sel changes take effect at the next sequence decision.
- irq = irq_en & (s_low|s_high|l_low|l_high), registered.
- Simultaneous EVAL flag-set and W1C on the same bit: the set wins.
- Threshold/WINDOW writes mid-run: WINDOW is latched at PRE; thresholds are sampled at EVAL.

Decomposition:
- Shared package holds register offsets, CTRL/STATUS bit indices, and FSM state encoding.
- One sub-module, ro_win_timer: loadable down-counter with load, enable and zero flag. It is reused for the RUN and SETTLE phases.

Test Plan:
1. Reset values: after reset, read all registers -> all 0x0000; ro_*_en=0; irq=0.
2. Single short measurement:
   - Setup: WINDOW=100, S_LO=50, S_HI=300; bench counter +2/cycle while enabled.
   - Stimulus: CTRL=0x0005.
   - Expect: ro_short_en high exactly 100 cycles; S_RES=200; STATUS=0x0002; irq=0.
3. Counter wrap:
   - Setup: start count 0xFFF0, +1/cycle, WINDOW=0x40.
   - Expect: S_RES=0x0040, no alarm.
4. Both sensors with high violation on long:
   - Setup: CTRL=0x001D; L_HI=10; long count delta 40.
   - Expect: short runs then long; ro_long_en never overlaps ro_short_en; STATUS.l_high=1; ERRCNT=1; irq=1.
   - Then write STATUS=0x0020 -> irq=0.
5. Continuous + abort:
   - Stimulus: CTRL=0x0007; abort mid-RUN.
   - Expect: en low next cycle, busy=0, S_RES unchanged.
   - Start during busy is ignored; start with sel=0 leaves busy=0.
6. Reset mid-RUN: pull puc_rst_n low asynchronously -> enables drop immediately (no clock edge) and all registers clear.

Source files
------------

// File: rtl/ro_meas_sched_pkg.sv
// Shared definitions for the RO measurement scheduler: register offsets,
// CTRL/STATUS bit positions, FSM and sensor-select encodings.
package ro_meas_sched_pkg;

  localparam logic [7:0] OFF_CTRL   = 8'h00;
  localparam logic [7:0] OFF_WINDOW = 8'h02;
  localparam logic [7:0] OFF_S_LO   = 8'h04;
  localparam logic [7:0] OFF_S_HI   = 8'h06;
  localparam logic [7:0] OFF_L_LO   = 8'h08;
  localparam logic [7:0] OFF_L_HI   = 8'h0A;
  localparam logic [7:0] OFF_S_RES  = 8'h0C;
  localparam logic [7:0] OFF_L_RES  = 8'h0E;
  localparam logic [7:0] OFF_STATUS = 8'h10;
  localparam logic [7:0] OFF_ERRCNT = 8'h12;

  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_SSEL  = 2;
  localparam int CTRL_LSEL  = 3;
  localparam int CTRL_IRQEN = 4;
  localparam int CTRL_ABORT = 5;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_SLOW  = 2;
  localparam int ST_SHIGH = 3;
  localparam int ST_LLOW  = 4;
  localparam int ST_LHIGH = 5;

  typedef enum logic [2:0] {
    FSM_IDLE, FSM_PRE, FSM_RUN, FSM_SETTLE, FSM_EVAL
  } fsm_t;

  typedef enum logic {SEL_SHORT = 1'b0, SEL_LONG = 1'b1} sel_t;

  // Timer reload for an N-cycle window; a zero window still runs one cycle.
  function automatic logic [15:0] win_load(input logic [15:0] win);
    return (win == 16'd0) ? 16'd0 : win - 16'd1;
  endfunction

endpackage

// File: rtl/ro_meas_sched_if.sv
// openMSP430 peripheral bus slice seen by the RO measurement scheduler.
interface ro_meas_sched_if;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;

  modport master (output per_addr, per_din, per_en, per_we, input per_dout);
  modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/ro_meas_sched_win_timer.sv
// Loadable down-counter with zero flag; shared by the RUN and SETTLE phases.
module ro_win_timer #(
  parameter int W = 16
)(
  input  logic         mclk,
  input  logic         puc_rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n)             cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ro_meas_sched.sv
// Ring-oscillator measurement scheduler: windows each RO enable in turn,
// snapshots its counter around the window and checks the delta against thresholds.
module ro_meas_sched
  import ro_meas_sched_pkg::*;
#(
  parameter logic [14:0] BASE_ADDR  = 15'h01C0,
  parameter int          DEC_WD     = 5,
  parameter int          SETTLE_CYC = 4,
  parameter int          WIN_W      = 16
)(
  input  logic           mclk,
  input  logic           puc_rst_n,
  ro_meas_sched_if.slave per,
  input  logic [15:0]    ro_short_cnt,
  input  logic [15:0]    ro_long_cnt,
  output logic           ro_short_en,
  output logic           ro_long_en,
  output logic           irq
);

  // ---- bus decode ----
  logic       reg_sel, reg_wr, reg_rd;
  logic [7:0] reg_off;

  assign reg_sel = per.per_en & (per.per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
  assign reg_off = 8'({per.per_addr[DEC_WD-2:0], 1'b0});
  assign reg_wr  = reg_sel & (|per.per_we);
  assign reg_rd  = reg_sel & ~(|per.per_we);

  logic wr_ctrl, wr_window, wr_slo, wr_shi, wr_llo, wr_lhi, wr_status, wr_errcnt;
  assign wr_ctrl   = reg_wr & (reg_off == OFF_CTRL);
  assign wr_window = reg_wr & (reg_off == OFF_WINDOW);
  assign wr_slo    = reg_wr & (reg_off == OFF_S_LO);
  assign wr_shi    = reg_wr & (reg_off == OFF_S_HI);
  assign wr_llo    = reg_wr & (reg_off == OFF_L_LO);
  assign wr_lhi    = reg_wr & (reg_off == OFF_L_HI);
  assign wr_status = reg_wr & (reg_off == OFF_STATUS);
  assign wr_errcnt = reg_wr & (reg_off == OFF_ERRCNT);

  // ---- registers ----
  logic        ctrl_cont, ctrl_ssel, ctrl_lsel, ctrl_irqen;
  logic [15:0] window, s_lo, s_hi, l_lo, l_hi, s_res, l_res, errcnt, snap;
  logic [5:1]  sticky, sticky_set, w1c;

  fsm_t state, state_nxt;
  sel_t sel, sel_nxt;

  logic abort_req, start_req, seq_done, eval_upd, busy;
  logic tmr_load, tmr_zero, tmr_dec;
  logic [WIN_W-1:0] tmr_val;

  assign busy      = (state != FSM_IDLE);
  assign abort_req = wr_ctrl & per.per_din[CTRL_ABORT];
  assign start_req = wr_ctrl & per.per_din[CTRL_START] & ~per.per_din[CTRL_ABORT] & ~busy &
                     (per.per_din[CTRL_SSEL] | per.per_din[CTRL_LSEL]);
  assign eval_upd  = (state == FSM_EVAL) & ~abort_req;
  assign tmr_dec   = (state == FSM_RUN) | (state == FSM_SETTLE);

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      ctrl_cont  <= 1'b0;
      ctrl_ssel  <= 1'b0;
      ctrl_lsel  <= 1'b0;
      ctrl_irqen <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_cont  <= per.per_din[CTRL_CONT];
      ctrl_ssel  <= per.per_din[CTRL_SSEL];
      ctrl_lsel  <= per.per_din[CTRL_LSEL];
      ctrl_irqen <= per.per_din[CTRL_IRQEN];
    end
  end

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      window <= '0;
      s_lo   <= '0;
      s_hi   <= '0;
      l_lo   <= '0;
      l_hi   <= '0;
    end else begin
      if (wr_window) window <= per.per_din;
      if (wr_slo)    s_lo   <= per.per_din;
      if (wr_shi)    s_hi   <= per.per_din;
      if (wr_llo)    l_lo   <= per.per_din;
      if (wr_lhi)    l_hi   <= per.per_din;
    end
  end

  // ---- FSM ----
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state <= FSM_IDLE;
      sel   <= SEL_SHORT;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    seq_done  = 1'b0;
    case (state)
      FSM_IDLE: if (start_req) begin
        state_nxt = FSM_PRE;
        sel_nxt   = per.per_din[CTRL_SSEL] ? SEL_SHORT : SEL_LONG;
      end
      FSM_PRE: begin
        state_nxt = FSM_RUN;
        tmr_load  = 1'b1;
        tmr_val   = WIN_W'(win_load(window));
      end
      FSM_RUN: if (tmr_zero) begin
        state_nxt = FSM_SETTLE;
        tmr_load  = 1'b1;
        tmr_val   = WIN_W'(SETTLE_CYC - 1);
      end
      FSM_SETTLE: if (tmr_zero) state_nxt = FSM_EVAL;
      FSM_EVAL: begin
        if (sel == SEL_SHORT && ctrl_lsel) begin
          state_nxt = FSM_PRE;
          sel_nxt   = SEL_LONG;
        end else begin
          seq_done = 1'b1;
          if (ctrl_cont && (ctrl_ssel || ctrl_lsel)) begin
            state_nxt = FSM_PRE;
            sel_nxt   = ctrl_ssel ? SEL_SHORT : SEL_LONG;
          end else begin
            state_nxt = FSM_IDLE;
          end
        end
      end
      default: state_nxt = FSM_IDLE;
    endcase
    if (abort_req) begin
      state_nxt = FSM_IDLE;
      tmr_load  = 1'b0;
      seq_done  = 1'b0;
    end
  end

  ro_win_timer #(.W(WIN_W)) u_timer (
    .mclk      (mclk),
    .puc_rst_n (puc_rst_n),
    .load      (tmr_load),
    .load_val  (tmr_val),
    .dec       (tmr_dec),
    .zero      (tmr_zero)
  );

  // Enables are registered off the next state so they drop cleanly on abort/reset.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      ro_short_en <= 1'b0;
      ro_long_en  <= 1'b0;
    end else begin
      ro_short_en <= (state_nxt == FSM_RUN) & (sel_nxt == SEL_SHORT);
      ro_long_en  <= (state_nxt == FSM_RUN) & (sel_nxt == SEL_LONG);
    end
  end

  // ---- snapshot and evaluation ----
  logic [15:0] cur_cnt, delta, cur_lo, cur_hi;
  logic        hit_lo, hit_hi;

  assign cur_cnt = (sel == SEL_LONG) ? ro_long_cnt : ro_short_cnt;
  assign cur_lo  = (sel == SEL_LONG) ? l_lo : s_lo;
  assign cur_hi  = (sel == SEL_LONG) ? l_hi : s_hi;
  assign delta   = cur_cnt - snap;
  assign hit_lo  = delta < cur_lo;
  assign hit_hi  = delta > cur_hi;

  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      snap  <= '0;
      s_res <= '0;
      l_res <= '0;
    end else begin
      if (state == FSM_PRE && !abort_req) snap <= cur_cnt;
      if (eval_upd && sel == SEL_SHORT)   s_res <= delta;
      if (eval_upd && sel == SEL_LONG)    l_res <= delta;
    end
  end

  always_comb begin
    sticky_set = '0;
    if (seq_done) sticky_set[ST_DONE] = 1'b1;
    if (eval_upd) begin
      if (sel == SEL_SHORT) begin
        sticky_set[ST_SLOW]  = hit_lo;
        sticky_set[ST_SHIGH] = hit_hi;
      end else begin
        sticky_set[ST_LLOW]  = hit_lo;
        sticky_set[ST_LHIGH] = hit_hi;
      end
    end
  end

  assign w1c = wr_status ? per.per_din[5:1] : '0;

  // Set terms are OR'd after the clear so an EVAL hit beats a same-cycle W1C.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      sticky <= '0;
      errcnt <= '0;
      irq    <= 1'b0;
    end else begin
      sticky <= (sticky & ~w1c) | sticky_set;
      if (wr_errcnt)
        errcnt <= '0;
      else if (eval_upd && (hit_lo || hit_hi) && errcnt != 16'hFFFF)
        errcnt <= errcnt + 16'd1;
      irq <= ctrl_irqen & (|sticky[5:2]);
    end
  end

  // ---- read mux ----
  logic [15:0] rd_data;

  always_comb begin
    rd_data = '0;
    case (reg_off)
      OFF_CTRL: begin
        rd_data[CTRL_CONT]  = ctrl_cont;
        rd_data[CTRL_SSEL]  = ctrl_ssel;
        rd_data[CTRL_LSEL]  = ctrl_lsel;
        rd_data[CTRL_IRQEN] = ctrl_irqen;
      end
      OFF_WINDOW: rd_data = window;
      OFF_S_LO:   rd_data = s_lo;
      OFF_S_HI:   rd_data = s_hi;
      OFF_L_LO:   rd_data = l_lo;
      OFF_L_HI:   rd_data = l_hi;
      OFF_S_RES:  rd_data = s_res;
      OFF_L_RES:  rd_data = l_res;
      OFF_STATUS: rd_data = {10'd0, sticky, busy};
      OFF_ERRCNT: rd_data = errcnt;
      default:    rd_data = '0;
    endcase
  end

  assign per.per_dout = reg_rd ? rd_data : 16'h0000;

endmodule

// File: tb/tb_ro_meas_sched.sv
// Randomized self-checking bench for ro_meas_sched against a measurement-level model.
`timescale 1ns/1ps
module tb_ro_meas_sched;

  localparam logic [13:0] BASE_W = 14'h00E0;

  logic        mclk = 1'b0;
  logic        puc_rst_n = 1'b0;
  logic [15:0] ro_short_cnt, ro_long_cnt;
  logic        ro_short_en, ro_long_en, irq;

  ro_meas_sched_if bus();

  ro_meas_sched #(.BASE_ADDR(15'h01C0), .DEC_WD(5), .SETTLE_CYC(4), .WIN_W(16)) dut (
    .mclk         (mclk),
    .puc_rst_n    (puc_rst_n),
    .per          (bus),
    .ro_short_cnt (ro_short_cnt),
    .ro_long_cnt  (ro_long_cnt),
    .ro_short_en  (ro_short_en),
    .ro_long_en   (ro_long_en),
    .irq          (irq)
  );

  always #5 mclk = ~mclk;

  // RO counter stand-ins and enable-window observers
  logic [15:0] s_step = 16'd1, l_step = 16'd1, s_preset = 16'd0, l_preset = 16'd0;
  logic        cnt_load = 1'b1, cyc_clr = 1'b1, ovl;
  int          s_en_cyc, l_en_cyc;

  always @(posedge mclk) begin
    if (cnt_load) begin
      ro_short_cnt <= s_preset;
      ro_long_cnt  <= l_preset;
    end else begin
      if (ro_short_en) ro_short_cnt <= ro_short_cnt + s_step;
      if (ro_long_en)  ro_long_cnt  <= ro_long_cnt + l_step;
    end
    if (cyc_clr) begin
      s_en_cyc <= 0;
      l_en_cyc <= 0;
      ovl      <= 1'b0;
    end else begin
      if (ro_short_en) s_en_cyc <= s_en_cyc + 1;
      if (ro_long_en)  l_en_cyc <= l_en_cyc + 1;
      if (ro_short_en && ro_long_en) ovl <= 1'b1;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---- reference model state ----
  logic [15:0] m_win, m_slo, m_shi, m_llo, m_lhi, m_sres, m_lres, m_err;
  logic [5:1]  m_st;
  logic        m_irqen;

  task automatic model_reset();
    m_win = 0; m_slo = 0; m_shi = 0; m_llo = 0; m_lhi = 0;
    m_sres = 0; m_lres = 0; m_err = 0; m_st = '0; m_irqen = 1'b0;
  endtask

  // Each selected sensor counts step per enabled cycle for max(WINDOW,1) cycles.
  task automatic model_meas(input logic ss, input logic ls);
    int n;
    logic [15:0] d;
    logic lo, hi;
    n = (m_win == 16'd0) ? 1 : int'(m_win);
    if (ss) begin
      d = 16'(32'(n) * 32'(s_step));
      m_sres = d; lo = d < m_slo; hi = d > m_shi;
      m_st[2] = m_st[2] | lo; m_st[3] = m_st[3] | hi;
      if ((lo || hi) && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end
    if (ls) begin
      d = 16'(32'(n) * 32'(l_step));
      m_lres = d; lo = d < m_llo; hi = d > m_lhi;
      m_st[4] = m_st[4] | lo; m_st[5] = m_st[5] | hi;
      if ((lo || hi) && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end
    m_st[1] = 1'b1;
  endtask

  // ---- bus tasks ----
  task automatic wr(input logic [7:0] off, input logic [15:0] v);
    @(negedge mclk);
    bus.per_addr = BASE_W + 14'(off >> 1);
    bus.per_din  = v;
    bus.per_we   = 2'b11;
    bus.per_en   = 1'b1;
    @(negedge mclk);
    bus.per_en   = 1'b0;
    bus.per_we   = 2'b00;
  endtask

  task automatic rd(input logic [7:0] off, output logic [15:0] v);
    @(negedge mclk);
    bus.per_addr = BASE_W + 14'(off >> 1);
    bus.per_we   = 2'b00;
    bus.per_en   = 1'b1;
    #1 v = bus.per_dout;
    bus.per_en   = 1'b0;
  endtask

  task automatic wreg(input logic [7:0] off, input logic [15:0] v);
    wr(off, v);
    case (off)
      8'h00: m_irqen = v[4];
      8'h02: m_win = v;
      8'h04: m_slo = v;
      8'h06: m_shi = v;
      8'h08: m_llo = v;
      8'h0A: m_lhi = v;
      8'h10: m_st  = m_st & ~v[5:1];
      8'h12: m_err = 16'd0;
      default: ;
    endcase
  endtask

  task automatic prep(input logic [15:0] sp, input logic [15:0] lp,
                      input logic [15:0] ss, input logic [15:0] ls);
    @(negedge mclk);
    s_preset = sp; l_preset = lp; s_step = ss; l_step = ls;
    cnt_load = 1'b1; cyc_clr = 1'b1;
    @(negedge mclk);
    cnt_load = 1'b0; cyc_clr = 1'b0;
  endtask

  task automatic wait_idle();
    logic [15:0] d;
    bit done_ok;
    done_ok = 1'b0;
    for (int k = 0; k < 3000 && !done_ok; k++) begin
      rd(8'h10, d);
      if (!d[0]) done_ok = 1'b1;
    end
    chk("busy_timeout", {31'd0, done_ok}, 32'd1);
  endtask

  task automatic wait_en(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge mclk);
      if (ro_short_en) seen = 1'b1;
    end
  endtask

  task automatic check_all(input logic ss, input logic ls);
    logic [15:0] d;
    int n;
    n = (m_win == 16'd0) ? 1 : int'(m_win);
    repeat (2) @(negedge mclk);
    chk("irq", {31'd0, irq}, {31'd0, m_irqen & (|m_st[5:2])});
    chk("s_en_cyc", s_en_cyc, ss ? n : 0);
    chk("l_en_cyc", l_en_cyc, ls ? n : 0);
    chk("overlap", {31'd0, ovl}, 32'd0);
    rd(8'h0C, d); chk("s_res", d, m_sres);
    rd(8'h0E, d); chk("l_res", d, m_lres);
    rd(8'h10, d); chk("status", d, {10'd0, m_st, 1'b0});
    rd(8'h12, d); chk("errcnt", d, m_err);
  endtask

  task automatic check_regs_zero();
    logic [15:0] d;
    logic [7:0] off;
    for (int i = 0; i < 10; i++) begin
      off = 8'(2 * i);
      rd(off, d);
      chk("reset_reg", {16'(off), d}, {16'(off), 16'h0000});
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [15:0] d, ctrl;
    logic ss, ls;
    bit seen;

    bus.per_addr = '0; bus.per_din = '0; bus.per_en = 1'b0; bus.per_we = 2'b00;
    model_reset();
    repeat (3) @(negedge mclk);
    puc_rst_n = 1'b1;
    cnt_load = 1'b0; cyc_clr = 1'b0;

    // reset state
    check_regs_zero();
    chk("rst_en", {30'd0, ro_short_en, ro_long_en}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // single short measurement
    wreg(8'h02, 16'd100); wreg(8'h04, 16'd50); wreg(8'h06, 16'd300);
    prep(16'h1234, 16'h0, 16'd2, 16'd1);
    wreg(8'h00, 16'h0005);
    wait_idle();
    model_meas(1'b1, 1'b0);
    chk("t2_en_cyc", s_en_cyc, 100);
    rd(8'h0C, d); chk("t2_s_res", d, 16'd200);
    rd(8'h10, d); chk("t2_status", d, 16'h0002);
    check_all(1'b1, 1'b0);

    // counter wrap
    wreg(8'h02, 16'h0040);
    prep(16'hFFF0, 16'h0, 16'd1, 16'd1);
    wreg(8'h00, 16'h0005);
    wait_idle();
    model_meas(1'b1, 1'b0);
    rd(8'h0C, d); chk("t3_s_res", d, 16'h0040);
    rd(8'h10, d); chk("t3_status", d, 16'h0002);
    check_all(1'b1, 1'b0);

    // both sensors, long-high violation
    wreg(8'h10, 16'h003E);
    wreg(8'h04, 16'd0); wreg(8'h06, 16'hFFFF);
    wreg(8'h08, 16'd0); wreg(8'h0A, 16'd10);
    wreg(8'h02, 16'd20);
    prep(16'h0100, 16'hFFE0, 16'd2, 16'd2);
    wreg(8'h00, 16'h001D);
    wait_idle();
    model_meas(1'b1, 1'b1);
    repeat (2) @(negedge mclk);
    chk("t4_irq", {31'd0, irq}, 32'd1);
    rd(8'h0E, d); chk("t4_l_res", d, 16'd40);
    rd(8'h10, d); chk("t4_status", d, 16'h0022);
    rd(8'h12, d); chk("t4_errcnt", d, 16'd1);
    check_all(1'b1, 1'b1);
    wreg(8'h10, 16'h0020);
    repeat (2) @(negedge mclk);
    chk("t4_irq_clr", {31'd0, irq}, 32'd0);
    rd(8'h10, d); chk("t4_status_clr", d, 16'h0002);

    // randomized single sequences
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 3) == 0) wreg(8'h12, 16'h0);
      wreg(8'h10, 16'($urandom_range(0, 63)) & 16'h003E);
      wreg(8'h02, ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 40)));
      wreg(8'h04, 16'($urandom_range(0, 800)));
      wreg(8'h06, 16'($urandom_range(0, 1600)));
      wreg(8'h08, 16'($urandom_range(0, 800)));
      wreg(8'h0A, 16'($urandom_range(0, 1600)));
      prep(16'($urandom), 16'($urandom), 16'($urandom_range(1, 40)), 16'($urandom_range(1, 40)));
      {ls, ss} = 2'($urandom_range(1, 3));
      ctrl = {11'd0, 1'($urandom_range(0, 1)), ls, ss, 2'b01};
      wreg(8'h00, ctrl);
      wait_idle();
      model_meas(ss, ls);
      check_all(ss, ls);
    end

    // continuous run, ignored start while busy, abort
    wreg(8'h10, 16'h003E);
    wreg(8'h02, 16'd200);
    prep(16'h0, 16'h0, 16'd3, 16'd3);
    wreg(8'h00, 16'h0007);
    wait_en(seen);
    chk("t5_en_seen", {31'd0, seen}, 32'd1);
    repeat (10) @(negedge mclk);
    wreg(8'h00, 16'h000B);
    chk("t5_busy_start", {30'd0, ro_short_en, ro_long_en}, 32'd2);
    wreg(8'h00, 16'h0020);
    chk("t5_abort_en", {30'd0, ro_short_en, ro_long_en}, 32'd0);
    rd(8'h10, d); chk("t5_status", d, 16'h0000);
    rd(8'h0C, d); chk("t5_s_res", d, m_sres);
    wreg(8'h00, 16'h0001);
    repeat (3) @(negedge mclk);
    rd(8'h10, d); chk("t5_nosel_busy", d, 16'h0000);

    // asynchronous reset in the middle of a window
    wreg(8'h02, 16'd100);
    wreg(8'h00, 16'h0015);
    wait_en(seen);
    chk("t6_en_seen", {31'd0, seen}, 32'd1);
    repeat (5) @(negedge mclk);
    #1 puc_rst_n = 1'b0;
    #1 chk("t6_async_en", {30'd0, ro_short_en, ro_long_en}, 32'd0);
    model_reset();
    repeat (2) @(negedge mclk);
    puc_rst_n = 1'b1;
    check_regs_zero();
    chk("t6_irq", {31'd0, irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
